// File: rtl/varredor_mux_if.sv
// Handshake bundle between the scan sequencer, the 8:1 byte multiplexer and the downstream consumer.
// The sequencer takes the slave view; the environment drives it through the master view.
interface varredor_mux_if #(
  parameter int LARGURA = 8
);
  logic               habilita;
  logic [7:0]         mascara;
  logic [LARGURA-1:0] dados_mux;
  logic               pronto;
  logic [2:0]         endereco;
  logic [LARGURA-1:0] dado_saida;
  logic [2:0]         canal_saida;
  logic               valido;
  logic               varredura_completa;

  modport master (
    output habilita, mascara, dados_mux, pronto,
    input  endereco, dado_saida, canal_saida, valido, varredura_completa
  );

  modport slave (
    input  habilita, mascara, dados_mux, pronto,
    output endereco, dado_saida, canal_saida, valido, varredura_completa
  );
endinterface

// File: rtl/varredor_mux.sv
// Scan sequencer for the 8:1 byte multiplexer: selects each enabled channel, waits ESPERA
// settle cycles, captures the byte and hands it downstream over valid/ready with its channel tag.
module varredor_mux #(
  parameter int LARGURA = 8,
  parameter int ESPERA  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  varredor_mux_if.slave bus
);

  typedef enum logic [1:0] {
    S_OCIOSO  = 2'd0,
    S_ESPERA  = 2'd1,
    S_ENTREGA = 2'd2
  } estado_t;

  localparam logic [3:0] CONT_INI = 4'(ESPERA - 1);

  estado_t    estado;
  logic [3:0] contador;
  logic [2:0] prox_canal;
  logic       prox_wrap;

  function automatic logic [2:0] menor_canal(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) idx = 3'(i);
    return idx;
  endfunction

  // Returns {wrap, index}: wrap is set when no enabled channel lies above the current one.
  function automatic logic [3:0] proximo_canal(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] idx;
    logic       achou;
    idx   = 3'd0;
    achou = 1'b0;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (i > int'(c))) begin
        idx   = 3'(i);
        achou = 1'b1;
      end
    if (!achou) idx = menor_canal(m);
    return {!achou, idx};
  endfunction

  always_comb begin
    {prox_wrap, prox_canal} = proximo_canal(bus.mascara, bus.canal_saida);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado                 <= S_OCIOSO;
      contador               <= 4'd0;
      bus.endereco           <= 3'd0;
      bus.dado_saida         <= {LARGURA{1'b0}};
      bus.canal_saida        <= 3'd0;
      bus.valido             <= 1'b0;
      bus.varredura_completa <= 1'b0;
    end else begin
      bus.varredura_completa <= 1'b0;
      case (estado)
        S_OCIOSO: begin
          if (bus.habilita && (bus.mascara != 8'd0)) begin
            bus.endereco <= menor_canal(bus.mascara);
            contador     <= CONT_INI;
            estado       <= S_ESPERA;
          end
        end
        S_ESPERA: begin
          // Dropping habilita wins over a capture due on the same edge.
          if (!bus.habilita) begin
            estado <= S_OCIOSO;
          end else if (contador != 4'd0) begin
            contador <= contador - 4'd1;
          end else begin
            bus.dado_saida  <= bus.dados_mux;
            bus.canal_saida <= bus.endereco;
            bus.valido      <= 1'b1;
            estado          <= S_ENTREGA;
          end
        end
        S_ENTREGA: begin
          if (bus.pronto) begin
            bus.valido <= 1'b0;
            if (prox_wrap) bus.varredura_completa <= 1'b1;
            if (bus.habilita && (bus.mascara != 8'd0)) begin
              bus.endereco <= prox_canal;
              contador     <= CONT_INI;
              estado       <= S_ESPERA;
            end else begin
              estado <= S_OCIOSO;
            end
          end
        end
        default: estado <= S_OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_varredor_mux.sv
// Directed bench for varredor_mux: full and sparse scans, backpressure, aborts, async reset,
// and settle-time measurement on instances built with ESPERA = 1, 2 and 15.
module tb_varredor_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       habilita;
  logic [7:0] mascara;
  logic       pronto;

  int n_total = 0;
  int n_ok    = 0;
  int ciclo   = 0;

  varredor_mux_if #(.LARGURA(8)) b1 ();
  varredor_mux_if #(.LARGURA(8)) b2 ();
  varredor_mux_if #(.LARGURA(8)) b15 ();

  assign b1.habilita  = habilita;
  assign b2.habilita  = habilita;
  assign b15.habilita = habilita;
  assign b1.mascara   = mascara;
  assign b2.mascara   = mascara;
  assign b15.mascara  = mascara;
  assign b1.pronto    = pronto;
  assign b2.pronto    = pronto;
  assign b15.pronto   = pronto;
  // Multiplexer model: channel i carries the byte 1 << i.
  assign b1.dados_mux  = 8'd1 << b1.endereco;
  assign b2.dados_mux  = 8'd1 << b2.endereco;
  assign b15.dados_mux = 8'd1 << b15.endereco;

  varredor_mux #(.LARGURA(8), .ESPERA(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  varredor_mux #(.LARGURA(8), .ESPERA(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(b2));
  varredor_mux #(.LARGURA(8), .ESPERA(15)) u15 (.clk(clk), .rst_n(rst_n), .bus(b15));

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_total++;
    if (obtido === esperado) n_ok++;
    else $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado);
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
    ciclo++;
  endtask

  task automatic espera_valido(input int limite);
    int n;
    n = 0;
    while (!b2.valido && n < limite) begin
      passo();
      n++;
    end
    verifica("timeout_valido", 32'(b2.valido), 32'd1);
  endtask

  initial begin
    int ult;
    int canais[3];
    bit visto;
    int ce1, cv1, ce2, cv2, ce15, cv15;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      habilita = 1'($urandom);
      mascara  = 8'($urandom);
      pronto   = 1'($urandom);
      passo();
    end
    verifica("rst_endereco", 32'(b2.endereco), 32'd0);
    verifica("rst_dado", 32'(b2.dado_saida), 32'd0);
    verifica("rst_canal", 32'(b2.canal_saida), 32'd0);
    verifica("rst_valido", 32'(b2.valido), 32'd0);
    verifica("rst_vc", 32'(b2.varredura_completa), 32'd0);

    // Full scan, mask FF
    habilita = 1'b1;
    mascara  = 8'hFF;
    pronto   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ult = 0;
    for (int k = 0; k < 8; k++) begin
      espera_valido(10);
      verifica("scan_dado", 32'(b2.dado_saida), 32'd1 << k);
      verifica("scan_canal", 32'(b2.canal_saida), 32'(k));
      if (k > 0) verifica("scan_intervalo", 32'(ciclo - ult), 32'd3);
      ult = ciclo;
      passo();
      verifica("scan_vc", 32'(b2.varredura_completa), (k == 7) ? 32'd1 : 32'd0);
    end
    espera_valido(10);
    verifica("wrap_dado", 32'(b2.dado_saida), 32'h01);
    verifica("wrap_canal", 32'(b2.canal_saida), 32'd0);

    // Sparse mask, takes effect at the next transfer
    mascara   = 8'b1010_0100;
    canais[0] = 2;
    canais[1] = 5;
    canais[2] = 7;
    passo();
    for (int k = 0; k < 3; k++) begin
      espera_valido(10);
      verifica("esparsa_dado", 32'(b2.dado_saida), 32'd1 << canais[k]);
      verifica("esparsa_canal", 32'(b2.canal_saida), 32'(canais[k]));
      passo();
      verifica("esparsa_vc", 32'(b2.varredura_completa), (k == 2) ? 32'd1 : 32'd0);
    end
    espera_valido(10);
    verifica("esparsa_wrap", 32'(b2.dado_saida), 32'h04);

    // Backpressure on channel 2
    pronto = 1'b0;
    for (int i = 0; i < 5; i++) begin
      passo();
      verifica("bp_valido", 32'(b2.valido), 32'd1);
    end
    verifica("bp_dado", 32'(b2.dado_saida), 32'h04);
    verifica("bp_canal", 32'(b2.canal_saida), 32'd2);
    verifica("bp_endereco", 32'(b2.endereco), 32'd2);
    pronto = 1'b1;
    passo();
    verifica("bp_transf_valido", 32'(b2.valido), 32'd0);
    verifica("bp_transf_end", 32'(b2.endereco), 32'd5);
    passo();
    verifica("bp_espera1", 32'(b2.valido), 32'd0);
    passo();
    verifica("bp_espera2", 32'(b2.valido), 32'd1);
    verifica("bp_prox_dado", 32'(b2.dado_saida), 32'h20);

    // Abort during the settle wait
    passo();
    habilita = 1'b0;
    visto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      passo();
      visto |= b2.valido;
    end
    verifica("abort_esp_valido", 32'(visto), 32'd0);
    verifica("abort_esp_end", 32'(b2.endereco), 32'd7);
    habilita = 1'b1;
    espera_valido(10);
    verifica("reinicio1_canal", 32'(b2.canal_saida), 32'd2);

    // Abort during delivery: the pending byte still completes
    habilita = 1'b0;
    pronto   = 1'b0;
    passo();
    passo();
    verifica("abort_ent_valido", 32'(b2.valido), 32'd1);
    verifica("abort_ent_dado", 32'(b2.dado_saida), 32'h04);
    pronto = 1'b1;
    passo();
    verifica("abort_ent_transf", 32'(b2.valido), 32'd0);
    visto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      passo();
      visto |= b2.valido;
    end
    verifica("abort_ent_ocioso", 32'(visto), 32'd0);
    verifica("abort_ent_end", 32'(b2.endereco), 32'd2);
    habilita = 1'b1;
    espera_valido(10);
    verifica("reinicio2_canal", 32'(b2.canal_saida), 32'd2);
    verifica("reinicio2_dado", 32'(b2.dado_saida), 32'h04);

    // Empty mask keeps the sequencer idle
    habilita = 1'b0;
    passo();
    mascara  = 8'h00;
    habilita = 1'b1;
    visto = 1'b0;
    for (int i = 0; i < 10; i++) begin
      passo();
      visto |= b2.valido;
    end
    verifica("vazia_valido", 32'(visto), 32'd0);
    verifica("vazia_end", 32'(b2.endereco), 32'd2);

    // Single channel repeats, pulsing varredura_completa every time
    mascara = 8'h10;
    for (int k = 0; k < 2; k++) begin
      espera_valido(10);
      verifica("unico_dado", 32'(b2.dado_saida), 32'h10);
      verifica("unico_canal", 32'(b2.canal_saida), 32'd4);
      passo();
      verifica("unico_vc", 32'(b2.varredura_completa), 32'd1);
    end

    // Asynchronous reset while a byte is pending
    espera_valido(10);
    pronto = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    verifica("rst_async_valido", 32'(b2.valido), 32'd0);
    verifica("rst_async_dado", 32'(b2.dado_saida), 32'd0);
    verifica("rst_async_canal", 32'(b2.canal_saida), 32'd0);

    // Settle time from select change to valido for each ESPERA
    habilita = 1'b0;
    mascara  = 8'h08;
    pronto   = 1'b1;
    passo();
    @(negedge clk);
    rst_n = 1'b1;
    passo();
    passo();
    habilita = 1'b1;
    ce1 = -1; cv1 = -1; ce2 = -1; cv2 = -1; ce15 = -1; cv15 = -1;
    for (int c = 0; c < 40; c++) begin
      passo();
      if (ce1 < 0 && b1.endereco == 3'd3) ce1 = c;
      if (cv1 < 0 && b1.valido) cv1 = c;
      if (ce2 < 0 && b2.endereco == 3'd3) ce2 = c;
      if (cv2 < 0 && b2.valido) cv2 = c;
      if (ce15 < 0 && b15.endereco == 3'd3) ce15 = c;
      if (cv15 < 0 && b15.valido) cv15 = c;
    end
    verifica("espera1_gap", 32'(cv1 - ce1), 32'd1);
    verifica("espera2_gap", 32'(cv2 - ce2), 32'd2);
    verifica("espera15_gap", 32'(cv15 - ce15), 32'd15);
    verifica("espera15_dado", 32'(b15.dado_saida), 32'h08);

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
